// File: rtl/wb_arbiter.sv
// Writeback-port controller: round-robin ALU/MEM arbitration onto the single
// register-file write port, plus the ECALL drain/call/write-a0/flush sequence.
module wb_arbiter #(
    parameter int REGBITS = 5,
    parameter int LOGSIZE = 64,
    parameter int PCBITS  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_alu_valid,
    input  logic [REGBITS-1:0] i_alu_rd,
    input  logic [LOGSIZE-1:0] i_alu_data,
    output logic               o_alu_ready,
    input  logic               i_mem_valid,
    input  logic [REGBITS-1:0] i_mem_rd,
    input  logic [LOGSIZE-1:0] i_mem_data,
    output logic               o_mem_ready,
    input  logic               i_is_flush,
    input  logic               i_ecall_req,
    input  logic [PCBITS-1:0]  i_ecall_pc,
    output logic               o_ecall_start,
    input  logic               i_ecall_done,
    input  logic [LOGSIZE-1:0] i_ecall_result,
    output logic               o_ecall_ack,
    output logic               o_rf_we,
    output logic [REGBITS-1:0] o_rf_rd,
    output logic [LOGSIZE-1:0] o_rf_data,
    output logic               o_flush_bit,
    output logic [PCBITS-1:0]  o_pc_after_flush
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_CALL, S_WAIT, S_WRITE, S_FLUSH
    } state_t;

    state_t             r_state;
    logic               r_last_mem;
    logic [LOGSIZE-1:0] r_a0;
    logic               r_ecall_start, r_ecall_ack, r_flush_bit, r_rf_we;
    logic [REGBITS-1:0] r_rf_rd;
    logic [LOGSIZE-1:0] r_rf_data;
    logic [PCBITS-1:0]  r_pc_after_flush;

    logic w_arb_en, w_alu_gnt, w_mem_gnt, w_ecall_go;

    assign w_arb_en  = i_rst && (r_state == S_IDLE) && !i_ecall_req;
    assign w_alu_gnt = w_arb_en && i_alu_valid && (!i_mem_valid || r_last_mem);
    assign w_mem_gnt = w_arb_en && i_mem_valid && (!i_alu_valid || !r_last_mem);
    // The requester still holds ecall_req in the cycle it sees ecall_ack;
    // that cycle must not start a second sequence.
    assign w_ecall_go = i_ecall_req && !r_ecall_ack;

    assign o_alu_ready      = w_alu_gnt;
    assign o_mem_ready      = w_mem_gnt;
    assign o_ecall_start    = r_ecall_start;
    assign o_ecall_ack      = r_ecall_ack;
    assign o_flush_bit      = r_flush_bit;
    assign o_pc_after_flush = r_pc_after_flush;
    assign o_rf_we          = r_rf_we;
    assign o_rf_rd          = r_rf_rd;
    assign o_rf_data        = r_rf_data;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state          <= S_IDLE;
            r_last_mem       <= 1'b0;
            r_a0             <= '0;
            r_ecall_start    <= 1'b0;
            r_ecall_ack      <= 1'b0;
            r_flush_bit      <= 1'b0;
            r_pc_after_flush <= '0;
            r_rf_we          <= 1'b0;
            r_rf_rd          <= '0;
            r_rf_data        <= '0;
        end else begin
            r_ecall_start <= 1'b0;
            r_ecall_ack   <= 1'b0;
            r_flush_bit   <= 1'b0;
            r_rf_we       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ecall_go) begin
                        r_state <= S_DRAIN;
                    end else if (w_arb_en) begin
                        if (i_alu_valid && i_mem_valid)
                            r_last_mem <= w_mem_gnt;
                        // A squashed ALU result is consumed but never written.
                        if (w_alu_gnt && !i_is_flush && i_alu_rd != '0) begin
                            r_rf_we   <= 1'b1;
                            r_rf_rd   <= i_alu_rd;
                            r_rf_data <= i_alu_data;
                        end else if (w_mem_gnt && i_mem_rd != '0) begin
                            r_rf_we   <= 1'b1;
                            r_rf_rd   <= i_mem_rd;
                            r_rf_data <= i_mem_data;
                        end
                    end
                end
                S_DRAIN: begin
                    r_ecall_start <= 1'b1;
                    r_state       <= S_CALL;
                end
                S_CALL, S_WAIT: begin
                    if (i_ecall_done) begin
                        r_a0    <= i_ecall_result;
                        r_state <= S_WRITE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WRITE: begin
                    r_rf_we   <= 1'b1;
                    r_rf_rd   <= REGBITS'(10);
                    r_rf_data <= r_a0;
                    r_state   <= S_FLUSH;
                end
                S_FLUSH: begin
                    r_flush_bit      <= 1'b1;
                    r_ecall_ack      <= 1'b1;
                    r_pc_after_flush <= i_ecall_pc + PCBITS'(4);
                    r_state          <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Controller for the writeback stage's single register-file write port. It arbitrates round-robin between the ALU and memory result streams and squashes ALU results on a pipeline flush. It also sequences ECALL handling: drain, invoke the external ecall unit, write a0, then pulse a flush with the restart PC. It sits between the execute/memory stages and the register file, replacing direct muxing of ALU and load results.

## Interface
- REGBITS, 5, register index width
- LOGSIZE, 64, data width
- PCBITS, 32, program counter width

- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- alu_valid  input  1  ALU result offered
- alu_rd  input  REGBITS  ALU destination register
- alu_data  input  LOGSIZE  ALU result
- alu_ready  output  1  ALU result accepted this cycle (combinational)
- mem_valid  input  1  load result offered
- mem_rd  input  REGBITS  load destination register
- mem_data  input  LOGSIZE  load data
- mem_ready  output  1  load result accepted this cycle (combinational)
- is_flush  input  1  squash the ALU offer present this cycle
- ecall_req  input  1  ECALL pending; level, held until ecall_ack
- ecall_pc  input  PCBITS  PC of the ECALL, stable while ecall_req is high
- ecall_start  output  1  one-cycle pulse to the ecall unit
- ecall_done  input  1  ecall unit finished; ecall_result valid
- ecall_result  input  LOGSIZE  return value for a0
- ecall_ack  output  1  one-cycle pulse; ECALL retired
- rf_we  output  1  register-file write enable
- rf_rd  output  REGBITS  write address
- rf_data  output  LOGSIZE  write data
- flush_bit  output  1  one-cycle pipeline flush
- pc_after_flush  output  PCBITS  restart PC, valid while flush_bit is high

## Operation
- FSM states: IDLE, DRAIN, CALL, WAIT, WRITE, FLUSH.
- **IDLE arbitration**
  - Ready outputs are asserted only in IDLE with ecall_req low.
  - With one valid source, that source is granted.
  - With both valid, the source opposite to last_grant is granted, and last_grant updates to the winner.
  - The non-granted ready is 0.
- **ALU squash**
  - If is_flush is high and ALU is granted, alu_ready=1 and the result is consumed but dropped: no write.
  - is_flush does not affect MEM.
- **Accepted result**
  - Next cycle: rf_we=1, rf_rd=rd, rf_data=data.
  - If rd==0: rf_we=0, result dropped.
- **ECALL sequence**
  - ecall_req high in IDLE: both readies 0 that cycle; go to DRAIN.
  - DRAIN lasts 1 cycle and retires any write registered the previous cycle.
  - CALL lasts 1 cycle: ecall_start=1.
  - WAIT holds until ecall_done. ecall_done sampled in CALL is also honoured.
  - WRITE: rf_we=1, rf_rd=10, rf_data=ecall_result (captured on ecall_done).
  - FLUSH: flush_bit=1, pc_after_flush=ecall_pc+4 (mod 2^PCBITS), ecall_ack=1; return to IDLE.
- Width rules: data is passed unmodified; the PC add truncates carry out.

## Timing
- **Reset** (rst low, asynchronous):
  - State=IDLE, last_grant=ALU (MEM wins the first tie).
  - rf_we=0, rf_rd=0, rf_data=0, flush_bit=0, pc_after_flush=0, ecall_start=0, ecall_ack=0.
  - Readies are 0 while rst is low.
- **Reset mid-ECALL**: the sequence is abandoned with no write or flush. ecall_req still high after release restarts the sequence from DRAIN.
- Write latency is 1 cycle from valid&ready to rf_we. Sustained throughput is one write per cycle.
- rf_rd and rf_data hold their last value when rf_we=0. flush_bit, ecall_start and ecall_ack are single-cycle pulses.
- **ECALL cycle count**, minimum, with ecall_done in CALL:
  - Request seen at cycle t.
  - DRAIN t+1, CALL t+2, WRITE t+3, FLUSH t+4.
  - a0 write visible t+4; flush visible t+5 (registered outputs).
- **Simultaneous events**:
  - ecall_req with alu_valid/mem_valid: ECALL wins; nothing is accepted.
  - is_flush with no ALU grant: no effect.
  - ecall_done outside CALL/WAIT: ignored.

## Test plan
- Reset: hold rst low with random inputs -> all outputs 0 and readies 0. Release -> idle; first tie grants MEM.
- Single source: alu_valid, rd=5, data=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_data=0x1234. rd=0 -> rf_we=0.
- Contention: both valid for 4 cycles with distinct rd -> grants MEM, ALU, MEM, ALU; four writes on consecutive cycles.
- Squash: both valid, ALU's turn, is_flush=1 -> alu_ready=1, no ALU write. MEM is granted next cycle.
- ECALL: ecall_req, ecall_pc=0x80000010, ecall_done 3 cycles after start, result=0x2A:
  - ecall_start pulses once.
  - rf_we writes x10=0x2A.
  - Then flush_bit=1, pc_after_flush=0x80000014, ecall_ack=1.
  - Readies stay 0 throughout.
- Wrap and mid-reset: ecall_pc=0xFFFFFFFC -> pc_after_flush=0. Assert rst during WAIT -> no write or flush; sequence restarts after release.
